adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter W, default 8: operand width in bits for both requesters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 A0, B0  input  W each  requester-0 operands.
REQ-005 V0  input  1  requester-0 request valid.
REQ-006 R0  output  1  requester-0 ready; the request is accepted when V0 and R0 are both high on a rising edge.
REQ-007 A1, B1, V1, R1  same as REQ-004..006  requester-1 port.
REQ-008 S  output  W+1  registered sum of the granted operands, with the carry in bit W.
REQ-009 SV  output  1  result valid.
REQ-010 SID  output  1  index of the requester that owns S.
REQ-011 SR  input  1  consumer ready; the result is taken when SV and SR are both high on a rising edge.

Function
REQ-012 The block shall contain one shared W-bit adder, and shall issue at most one request to it per cycle.
REQ-013 The FSM shall have two states, IDLE and HOLD.
  - IDLE -> HOLD on any acceptance.
  - HOLD -> IDLE on result taken with no new acceptance that cycle.
  - HOLD -> HOLD on result taken together with a new acceptance.
REQ-014 Ready outputs shall be combinational and shall depend only on state, SR and the arbiter decision.
  - Rx is high only for the granted requester.
  - A grant exists only when the state is IDLE, or the state is HOLD and SR is high (pass-through, no bubble).
REQ-015 On acceptance, the block shall register S = Ax + Bx zero-extended to W+1 bits, set SID = x, and set SV = 1 on the next cycle, giving a latency of 1 cycle.
REQ-016 While SV = 1 and SR = 0, S, SV and SID shall hold stable, and both Rx shall be low.
REQ-017 A requester shall keep Vx and its operands stable until accepted; the block shall not drop a held request.
REQ-018 The arbiter shall evaluate only Vx inputs that are high; with a single valid requester, that requester shall be granted.
REQ-019 Sustained throughput shall be 1 result per cycle when SR is held high.
REQ-020 The sum shall be exact: (2^W-1) + (2^W-1) = 2^(W+1)-2, with no wrap or saturation.

Reset
REQ-021 While rst is high:
  - state shall be IDLE, SV = 0, S = 0, SID = 0, R0 = R1 = 0;
  - the round-robin pointer shall favour requester 0.
REQ-022 Reset asserted while in HOLD shall discard the pending result with no handshake.
REQ-023 The first acceptance shall be possible on the first rising edge after rst deasserts.

Configuration
REQ-024 Macro ADDER_ARB_RR_EN selects the arbitration policy.
REQ-025 ADDER_ARB_RR_EN defined: round-robin arbitration.
  - On simultaneous V0/V1, the requester not granted last shall win.
  - The pointer shall update only on acceptance.
REQ-026 ADDER_ARB_RR_EN undefined: fixed priority, with requester 0 always winning ties; no pointer register shall exist.

Structure
REQ-027 A shared package adder_arb_pkg shall hold:
  - the state enum (IDLE, HOLD);
  - the requester-count constant NREQ = 2;
  - the default width constant.
REQ-028 The W-bit adder shall be a separate combinational sub-module, add_core, with ports A, B and S (W+1 bits); the arbiter, FSM and output register shall stay in adder_arbiter.

Verification
REQ-029 Reset: after rst is held for 3 cycles then released, SV = 0, S = 0, R0 = R1 = 0 during reset, and a V0 pulse is accepted on the first edge after release.
REQ-030 Single requester: A0 = 35, B0 = 24, V0 = 1, SR = 1 -> next cycle SV = 1, S = 59, SID = 0.
REQ-031 Carry: A1 = 255, B1 = 255 -> S = 510 (bit 8 set), SID = 1; A0 = 100, B0 = 127 -> S = 227.
REQ-032 Contention with ADDER_ARB_RR_EN: V0 = V1 = 1 held for 4 cycles with SR = 1.
  - Required SID sequence: 0, 1, 0, 1.
  - Without the macro, the required sequence is 0, 0, 0, 0.
REQ-033 Backpressure: SR = 0 for 5 cycles while SV = 1 -> S and SID stable, R0 = R1 = 0; SR = 1 -> result taken and the next request accepted in the same cycle.
REQ-034 Reset mid-operation: rst asserted in HOLD with SR = 0 -> SV = 0 on the next cycle, and no stale result appears after release.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the two-requester adder arbiter.
package adder_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int NREQ      = 2;
  localparam int DEFAULT_W = 8;

endpackage

// File: rtl/adder_arbiter_add_core.sv
// Combinational W-bit adder; the carry lands in bit W of the result.
module add_core
  import adder_arb_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W:0]   S
);

  assign S = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/adder_arbiter.sv
// Two requesters share one adder; result held until the consumer takes it.
// Define ADDER_ARB_RR_EN for round-robin arbitration (default: fixed priority, requester 0 wins).
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] A0,
  input  logic [W-1:0] B0,
  input  logic         V0,
  output logic         R0,
  input  logic [W-1:0] A1,
  input  logic [W-1:0] B1,
  input  logic         V1,
  output logic         R1,
  output logic [W:0]   S,
  output logic         SV,
  output logic         SID,
  input  logic         SR
);

  state_e          state_q, state_d;
  logic            sv_q, sv_d;
  logic [W:0]      s_q, s_d;
  logic            sid_q, sid_d;
  logic [NREQ-1:0] gnt;
  logic            grant_ok;
  logic            acc;
  logic            take;
  logic [W-1:0]    add_a, add_b;
  logic [W:0]      sum;

`ifdef ADDER_ARB_RR_EN
  // ptr_q high means requester 1 is favoured on the next tie.
  logic ptr_q, ptr_d;
`endif

  always_comb begin
    gnt = '0;
    if (V0 && V1) begin
`ifdef ADDER_ARB_RR_EN
      gnt = ptr_q ? 2'b10 : 2'b01;
`else
      gnt = 2'b01;
`endif
    end else begin
      gnt = {V1, V0};
    end
  end

  // A held result blocks new grants unless the consumer drains it this cycle.
  assign grant_ok = (state_q == IDLE) || SR;
  assign R0       = !rst && grant_ok && gnt[0];
  assign R1       = !rst && grant_ok && gnt[1];
  assign acc      = (V0 && R0) || (V1 && R1);
  assign take     = sv_q && SR;

  assign add_a = gnt[1] ? A1 : A0;
  assign add_b = gnt[1] ? B1 : B0;

  add_core #(.W(W)) u_add_core (
    .A (add_a),
    .B (add_b),
    .S (sum)
  );

  always_comb begin
    state_d = state_q;
    sv_d    = sv_q;
    s_d     = s_q;
    sid_d   = sid_q;
    if (acc) begin
      state_d = HOLD;
      sv_d    = 1'b1;
      s_d     = sum;
      sid_d   = gnt[1];
    end else if (take) begin
      state_d = IDLE;
      sv_d    = 1'b0;
    end
  end

`ifdef ADDER_ARB_RR_EN
  assign ptr_d = acc ? gnt[0] : ptr_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sv_q    <= 1'b0;
      s_q     <= '0;
      sid_q   <= 1'b0;
`ifdef ADDER_ARB_RR_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sv_q    <= sv_d;
      s_q     <= s_d;
      sid_q   <= sid_d;
`ifdef ADDER_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign S   = s_q;
  assign SV  = sv_q;
  assign SID = sid_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed-vector bench for adder_arbiter with hand-computed expected values.
module tb_adder_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] A0, B0, A1, B1;
  logic         V0, V1, R0, R1;
  logic [W:0]   S;
  logic         SV, SID, SR;

  int n_vec = 0;
  int n_err = 0;

  adder_arbiter #(.W(W)) dut (
    .clk (clk), .rst (rst),
    .A0  (A0),  .B0  (B0), .V0 (V0), .R0 (R0),
    .A1  (A1),  .B1  (B1), .V1 (V1), .R1 (R1),
    .S   (S),   .SV  (SV), .SID (SID), .SR (SR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_sid;
    rst = 1'b1; SR = 1'b1;
    V0 = 1'b1; A0 = 8'd35; B0 = 8'd24;
    V1 = 1'b0; A1 = '0;    B1 = '0;

    // Reset held for three cycles with a pending V0
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_sv", SV, 0);
      chk("rst_s",  S,  0);
      chk("rst_r0", R0, 0);
      chk("rst_r1", R1, 0);
    end
    rst = 1'b0;
    #1;
    chk("rel_r0", R0, 1);
    step();
    V0 = 1'b0;
    chk("single_sv",  SV,  1);
    chk("single_s",   S,   59);
    chk("single_sid", SID, 0);
    step();
    chk("single_drain_sv", SV, 0);

    // Carry, then pass-through acceptance while the result is drained
    V1 = 1'b1; A1 = 8'd255; B1 = 8'd255;
    step();
    V1 = 1'b0;
    V0 = 1'b1; A0 = 8'd100; B0 = 8'd127;
    chk("carry_s",   S,    510);
    chk("carry_b8",  S[8], 1);
    chk("carry_sid", SID,  1);
    chk("carry_sv",  SV,   1);
    #1;
    chk("pass_r0", R0, 1);
    step();
    V0 = 1'b0;
    chk("add227_s",   S,   227);
    chk("add227_sid", SID, 0);
    chk("add227_sv",  SV,  1);
    step();
    chk("add227_drain_sv", SV, 0);

    // Backpressure with a queued requester-1 operation
    V0 = 1'b1; A0 = 8'd5; B0 = 8'd6;
    step();
    V0 = 1'b0; SR = 1'b0;
    V1 = 1'b1; A1 = 8'd7; B1 = 8'd8;
    chk("bp_first_s", S, 11);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_r0", R0, 0);
      chk("bp_r1", R1, 0);
      step();
      chk("bp_sv",  SV,  1);
      chk("bp_s",   S,   11);
      chk("bp_sid", SID, 0);
    end
    SR = 1'b1;
    #1;
    chk("bp_release_r1", R1, 1);
    step();
    V1 = 1'b0;
    chk("bp_next_sv",  SV,  1);
    chk("bp_next_s",   S,   15);
    chk("bp_next_sid", SID, 1);
    step();
    chk("bp_drain_sv", SV, 0);

    // Reset while holding a result nobody took
    SR = 1'b0;
    V0 = 1'b1; A0 = 8'd9; B0 = 8'd9;
    step();
    V0 = 1'b0;
    chk("mid_hold_sv", SV, 1);
    chk("mid_hold_s",  S,  18);
    rst = 1'b1;
    step();
    chk("mid_rst_sv", SV, 0);
    chk("mid_rst_s",  S,  0);
    rst = 1'b0;
    SR = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("mid_after_sv", SV, 0);
    end

    // Contention: both requesters valid for four cycles
`ifdef ADDER_ARB_RR_EN
    exp_sid = 4'b1010;
`else
    exp_sid = 4'b0000;
`endif
    V0 = 1'b1; A0 = 8'd1;  B0 = 8'd2;
    V1 = 1'b1; A1 = 8'd10; B1 = 8'd20;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("cont_sv",  SV,  1);
      chk("cont_sid", SID, exp_sid[i]);
      chk("cont_s",   S,   exp_sid[i] ? 30 : 3);
    end
    V0 = 1'b0; V1 = 1'b0;
    step();
    chk("cont_drain_sv", SV, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
